// File: rtl/mdom_hdr_bundle_mux.sv
// rtl/mdom_hdr_bundle_mux.sv - round-robin collector and word serializer for mDOM header bundles
//
// Purpose:
//   Collects one HDR_W-bit header bundle per channel over a valid/ready
//   handshake. Channels are picked round-robin. The bundle's channel-index
//   field (top CH_IDX_W bits) is overwritten with the granted channel number.
//   The header is then emitted as a WORD_W-bit word stream, least-significant
//   word first, with a last flag on the final word.
//
// Ports:
//   clk        system clock (single clock domain)
//   rst        synchronous reset, active high
//   in_bundle  N_CHAN packed bundles, channel c at [c*HDR_W +: HDR_W]
//   in_valid   per-channel header available
//   in_ready   one-hot grant (or zero), only asserted in IDLE
//   out_word   serialized header word
//   out_valid  out_word is valid
//   out_last   final word of the current header
//   out_ready  downstream accepts the word
//   busy       high while a header is being sent
//   hdr_cnt    count of headers fully emitted, wraps
//
// Configuration:
//   MDOM_HDR_SEQNUM_EN  when defined, a 16-bit header sequence number is
//                       appended as one extra word after the header words,
//                       and out_last moves onto that word.

module mdom_hdr_bundle_mux #(
    parameter int N_CHAN   = 24,
    parameter int HDR_W    = 111,
    parameter int CH_IDX_W = 5,
    parameter int WORD_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CHAN*HDR_W-1:0]  in_bundle,
    input  logic [N_CHAN-1:0]        in_valid,
    output logic [N_CHAN-1:0]        in_ready,
    output logic [WORD_W-1:0]        out_word,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [31:0]              hdr_cnt
);

    localparam int NW    = (HDR_W + WORD_W - 1) / WORD_W;
`ifdef MDOM_HDR_SEQNUM_EN
    localparam int NWT   = NW + 1;
`else
    localparam int NWT   = NW;
`endif
    localparam int SEL_W = $clog2(N_CHAN);
    localparam int WI_W  = $clog2(NWT + 1);
    localparam int PAD_W = NW * WORD_W;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   rr_ptr;
    logic [WI_W-1:0]    word_idx;
    logic [HDR_W-1:0]   hdr_reg;

`ifdef MDOM_HDR_SEQNUM_EN
    logic [15:0]        seq_cnt;
`endif

    // ------------------------------------------------------------------
    // Round-robin grant: first requesting channel at or above rr_ptr,
    // wrapping modulo N_CHAN.
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]   grant;
    logic               grant_found;

    always_comb begin
        int j;
        j           = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int i = 0; i < N_CHAN; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_CHAN) begin
                j = j - N_CHAN;
            end
            if (!grant_found && in_valid[SEL_W'(j)]) begin
                grant_found = 1'b1;
                grant       = SEL_W'(j);
            end
        end
    end

    // A transfer happens only from IDLE. Holding in_ready low during rst
    // makes a simultaneous reset and request look like no transfer to the
    // sender, which then retries.
    logic take;
    assign take = (state == IDLE) && grant_found && !rst;

    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[grant] = 1'b1;
        end
    end

    logic [HDR_W-1:0] sel_bundle;
    assign sel_bundle = in_bundle[int'(grant)*HDR_W +: HDR_W];

    // ------------------------------------------------------------------
    // Output word selection from the latched header.
    // ------------------------------------------------------------------
    logic [PAD_W-1:0]  hdr_pad;
    logic [WORD_W-1:0] word_sel;
    logic              at_last;

    assign at_last = (word_idx == WI_W'(NWT - 1));

    always_comb begin
        hdr_pad              = '0;
        hdr_pad[HDR_W-1:0]   = hdr_reg;
        word_sel             = '0;
`ifdef MDOM_HDR_SEQNUM_EN
        if (word_idx == WI_W'(NW)) begin
            word_sel = WORD_W'(seq_cnt);
        end else begin
            word_sel = hdr_pad[int'(word_idx)*WORD_W +: WORD_W];
        end
`else
        word_sel = hdr_pad[int'(word_idx)*WORD_W +: WORD_W];
`endif
    end

    // Outputs are decoded from registered state only, so out_word and
    // out_last hold while out_ready is low.
    assign busy      = (state == SEND);
    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && at_last;
    assign out_word  = (state == SEND) ? word_sel : '0;

    // ------------------------------------------------------------------
    // Control FSM.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            word_idx <= '0;
            hdr_reg  <= '0;
            hdr_cnt  <= '0;
`ifdef MDOM_HDR_SEQNUM_EN
            seq_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        hdr_reg  <= {CH_IDX_W'(grant), sel_bundle[HDR_W-CH_IDX_W-1:0]};
                        word_idx <= '0;
                        state    <= SEND;
                        if (grant == SEL_W'(N_CHAN - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= grant + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (at_last) begin
                            word_idx <= '0;
                            hdr_cnt  <= hdr_cnt + 32'd1;
                            state    <= IDLE;
`ifdef MDOM_HDR_SEQNUM_EN
                            seq_cnt  <= seq_cnt + 16'd1;
`endif
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdom_hdr_bundle_mux.sv
// tb/tb_mdom_hdr_bundle_mux.sv - directed self-checking bench for mdom_hdr_bundle_mux
module tb_mdom_hdr_bundle_mux;

    localparam int N_CHAN   = 24;
    localparam int HDR_W    = 111;
    localparam int CH_IDX_W = 5;
    localparam int WORD_W   = 16;
    localparam int NW       = 7;
`ifdef MDOM_HDR_SEQNUM_EN
    localparam int NWT      = 8;
`else
    localparam int NWT      = 7;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_CHAN*HDR_W-1:0] in_bundle;
    logic [N_CHAN-1:0]       in_valid;
    logic [N_CHAN-1:0]       in_ready;
    logic [WORD_W-1:0]       out_word;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ready;
    logic                    busy;
    logic [31:0]             hdr_cnt;

    logic [HDR_W-1:0]        bundles [N_CHAN];

    int          n_vec   = 0;
    int          n_miss  = 0;
    int          cyc     = 0;
    int          exp_cnt = 0;
    logic [15:0] exp_seq = 16'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar c = 0; c < N_CHAN; c++) begin : g_pack
        assign in_bundle[c*HDR_W +: HDR_W] = bundles[c];
    end

    mdom_hdr_bundle_mux #(
        .N_CHAN   (N_CHAN),
        .HDR_W    (HDR_W),
        .CH_IDX_W (CH_IDX_W),
        .WORD_W   (WORD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bundle (in_bundle),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .hdr_cnt   (hdr_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WORD_W-1:0] exp_word(input int ch, input int w);
        logic [NW*WORD_W-1:0] p;
        p                        = '0;
        p[HDR_W-1:0]             = bundles[ch];
        p[HDR_W-1 -: CH_IDX_W]   = CH_IDX_W'(ch);
        if (w >= NW) return exp_seq;
        return p[w*WORD_W +: WORD_W];
    endfunction

    function automatic logic [N_CHAN-1:0] onehot(input int ch);
        logic [N_CHAN-1:0] v;
        v     = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

    // Called at posedge+1 in IDLE with the request already driven.
    task automatic recv_hdr(input int ch, output int t_grant);
        #1;
        chk("in_ready_grant", in_ready, onehot(ch));
        t_grant = cyc;
        step();
        for (int w = 0; w < NWT; w++) begin
            chk("out_valid", out_valid, 1'b1);
            chk("out_word", out_word, exp_word(ch, w));
            chk("out_last", out_last, (w == NWT - 1));
            step();
        end
        exp_cnt++;
        exp_seq++;
        chk("hdr_cnt", hdr_cnt, exp_cnt);
        chk("idle_valid", out_valid, 1'b0);
    endtask

    initial begin
        int t, prev, hs, k;
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        for (int c = 0; c < N_CHAN; c++) begin
            bundles[c] = HDR_W'({4{32'h9E37_79B9 ^ (32'(c) * 32'h0101_0101)}});
        end
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        step();
        step();

        // Reset state.
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hdr_cnt", hdr_cnt, 0);
        rst = 1'b0;

        // Channel 3 with an all-ones bundle: index field forced to 3.
        bundles[3] = '1;
        in_valid   = onehot(3);
        #1;
        chk("ch3_in_ready", in_ready, 24'h8);
        step();
        in_valid = '0;
        for (int w = 0; w < NWT; w++) begin
            chk("ch3_valid", out_valid, 1'b1);
            chk("ch3_word", out_word, (w < 6) ? 16'hFFFF : ((w == 6) ? 16'h0FFF : exp_seq));
            chk("ch3_last", out_last, (w == NWT - 1));
            step();
        end
        exp_cnt++;
        exp_seq++;
        chk("ch3_hdr_cnt", hdr_cnt, 1);
        chk("ch3_busy", busy, 0);

        // Reset while word 3 is pending (rr_ptr is 4, so ch5 is granted).
        in_valid = onehot(5);
        #1;
        chk("mid_in_ready", in_ready, onehot(5));
        step();
        in_valid = '0;
        for (int w = 0; w < 3; w++) begin
            chk("mid_word", out_word, exp_word(5, w));
            step();
        end
        chk("mid_word3", out_word, exp_word(5, 3));
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        exp_seq = 16'd0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_word", out_word, 0);
        chk("mid_rst_cnt", hdr_cnt, 0);
        // rr_ptr back at 0 means ch5 wins over ch23.
        in_valid = onehot(5) | onehot(23);
        recv_hdr(5, t);
        in_valid = '0;

        // Reset together with a request: no transfer is taken.
        in_valid = '1;
        rst      = 1'b1;
        #1;
        chk("simul_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        exp_cnt = 0;
        exp_seq = 16'd0;
        chk("simul_valid", out_valid, 0);
        chk("simul_cnt", hdr_cnt, 0);

        // All channels requesting: strict rotation, NWT+1 cycles apart.
        prev = 0;
        for (int n = 0; n < N_CHAN + 1; n++) begin
            recv_hdr(n % N_CHAN, t);
            if (n > 0) chk("rr_period", 64'(t - prev), 64'(NWT + 1));
            prev = t;
        end
        in_valid = '0;

        // Backpressure on ch7 with out_ready 1,0,0,1 repeating.
        in_valid = onehot(7);
        #1;
        chk("bp_in_ready", in_ready, onehot(7));
        step();
        in_valid = '0;
        hs = 0;
        k  = 0;
        while (out_valid && k < 40) begin
            out_ready = pat[k % 4];
            #1;
            chk("bp_word", out_word, exp_word(7, hs));
            chk("bp_last", out_last, (hs == NWT - 1));
            if (out_ready) hs++;
            k++;
            step();
        end
        out_ready = 1'b1;
        exp_cnt++;
        exp_seq++;
        chk("bp_handshakes", hs, NWT);
        chk("bp_busy", busy, 0);
        chk("bp_hdr_cnt", hdr_cnt, exp_cnt);

        // ch1 alone moves rr_ptr to 2, then ch1/ch20 alternate starting at 20.
        in_valid = onehot(1);
        recv_hdr(1, t);
        in_valid = onehot(1) | onehot(20);
        recv_hdr(20, t);
        recv_hdr(1, t);
        recv_hdr(20, t);
        in_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
